// File: rtl/div_unit_if.sv
// Command/result bundle for the DIV/IDIV unit.
// Handshake: start is looked at only while the unit is idle (busy = 0 and
// done = 0); the operands are captured on that same edge and never read again.
// busy is high from the capturing edge until done rises; done is a single-cycle
// pulse, and quotient, remainder and div_err are meaningful while it is high.
// The next start can be taken on the edge after the done cycle.
interface div_unit_if;
  logic        start;
  logic        isize;
  logic        signed_op;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_err;
  logic [1:0]  state_dbg;

  modport master (
    output start, isize, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_err, state_dbg
  );

  modport slave (
    input  start, isize, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_err, state_dbg
  );
endinterface

// File: rtl/div_unit.sv
// Sequential 8086 DIV/IDIV unit: restoring division on magnitudes, one
// quotient bit per clock, followed by a sign fix-up and range check.
module div_unit (
  input  logic        clock,
  input  logic        reset_n,
  div_unit_if.slave   dif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;

  logic        size_q;      // 0 = byte, 1 = word
  logic        sgn_op_q;
  logic        dvd_sgn_q;
  logic        dvs_sgn_q;
  logic        err_q;
  logic [16:0] r_q;         // partial remainder, N+1 bits used
  logic [15:0] lo_q;        // remaining dividend bits, MSB-aligned
  logic [15:0] dvs_q;       // divisor magnitude
  logic [15:0] q_acc;       // quotient bits shifted in from the right
  logic [4:0]  cnt_q;
  logic [15:0] quo_q;
  logic [15:0] rem_q;

  // Start-time decode of signs and magnitudes
  logic        st_dvd_sgn, st_dvs_sgn;
  logic [15:0] dvd16, dvs8_mag;
  logic [7:0]  dvs8;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag, hi_mag, lo_init;
  logic        st_div0, st_ovf;

  // Loop and fix-up datapath
  logic [16:0] r_sh, r_sub;
  logic        fits;
  logic [15:0] q_mag, r_mag, q_res, r_res;
  logic        range_err;

  // Operand magnitudes and start-time error detection
  always_comb begin
    st_dvd_sgn = dif.signed_op & (dif.isize ? dif.dividend[31] : dif.dividend[15]);
    st_dvs_sgn = dif.signed_op & (dif.isize ? dif.divisor[15] : dif.divisor[7]);
    dvd16      = dif.dividend[15:0];
    dvs8       = dif.divisor[7:0];
    dvs8_mag   = {8'h00, (st_dvs_sgn ? -dvs8 : dvs8)};
    if (dif.isize) begin
      dvd_mag = st_dvd_sgn ? -dif.dividend : dif.dividend;
      dvs_mag = st_dvs_sgn ? -dif.divisor : dif.divisor;
      hi_mag  = dvd_mag[31:16];
      lo_init = dvd_mag[15:0];
    end else begin
      dvd_mag = {16'h0000, (st_dvd_sgn ? -dvd16 : dvd16)};
      dvs_mag = dvs8_mag;
      hi_mag  = {8'h00, dvd_mag[15:8]};
      lo_init = {dvd_mag[7:0], 8'h00};
    end
    st_div0 = (dvs_mag == 16'h0000);
    // A high half not below the divisor means the quotient needs more than N bits.
    st_ovf  = (hi_mag >= dvs_mag);
  end

  // One restoring step plus the sign fix-up and signed range check
  always_comb begin
    r_sh  = {r_q[15:0], lo_q[15]};
    fits  = (r_sh >= {1'b0, dvs_q});
    r_sub = r_sh - {1'b0, dvs_q};
    q_mag = size_q ? q_acc : {8'h00, q_acc[7:0]};
    r_mag = r_q[15:0];
    q_res = (dvd_sgn_q ^ dvs_sgn_q) ? -q_mag : q_mag;
    r_res = dvd_sgn_q ? -r_mag : r_mag;
    if (!size_q) begin
      q_res[15:8] = 8'h00;
      r_res[15:8] = 8'h00;
    end
    // Magnitude 0x80 / 0x8000 is rejected even for a negative quotient.
    range_err = sgn_op_q & (size_q ? (q_mag > 16'h7FFF) : (q_mag > 16'h007F));
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (dif.start) begin
        // Signed overflow still runs the loop so its timing matches IDIV.
        if (st_div0 || (st_ovf && !dif.signed_op)) state_nxt = S_FIX;
        else                                        state_nxt = S_LOOP;
      end
      S_LOOP: if (cnt_q == 5'd1) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, shift/subtract, result commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= 1'b0;
      sgn_op_q  <= 1'b0;
      dvd_sgn_q <= 1'b0;
      dvs_sgn_q <= 1'b0;
      err_q     <= 1'b0;
      r_q       <= 17'd0;
      lo_q      <= 16'h0000;
      dvs_q     <= 16'h0000;
      q_acc     <= 16'h0000;
      cnt_q     <= 5'd0;
      quo_q     <= 16'h0000;
      rem_q     <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: if (dif.start) begin
          size_q    <= dif.isize;
          sgn_op_q  <= dif.signed_op;
          dvd_sgn_q <= st_dvd_sgn;
          dvs_sgn_q <= st_dvs_sgn;
          err_q     <= st_div0 | st_ovf;
          r_q       <= {1'b0, hi_mag};
          lo_q      <= lo_init;
          dvs_q     <= dvs_mag;
          q_acc     <= 16'h0000;
          cnt_q     <= dif.isize ? 5'd16 : 5'd8;
        end
        S_LOOP: begin
          r_q   <= fits ? r_sub : r_sh;
          lo_q  <= {lo_q[14:0], 1'b0};
          q_acc <= {q_acc[14:0], fits};
          cnt_q <= cnt_q - 5'd1;
        end
        S_FIX: begin
          err_q <= err_q | range_err;
          if (!(err_q || range_err)) begin
            quo_q <= q_res;
            rem_q <= r_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.busy      = (state == S_LOOP) || (state == S_FIX);
  assign dif.done      = (state == S_DONE);
  assign dif.div_err   = (state == S_DONE) && err_q;
  assign dif.quotient  = quo_q;
  assign dif.remainder = rem_q;
  assign dif.state_dbg = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/IDIV vectors, latency,
// handshake corner cases and asynchronous reset during a word divide.
module tb_div_unit;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   done_cnt;

  div_unit_if dif ();

  div_unit u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dif     (dif)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every done pulse seen by the design's clock
  always @(posedge clock) if (dif.done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Wait (bounded) for done after the start edge; returns latency in edges
  task automatic wait_done(input string tag, output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (dif.done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one operation from a negedge and check the outcome
  task automatic run_op(input string tag, input logic sz, input logic sg,
                        input logic [31:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ee, input int elat);
    int lat;
    bit seen;
    dif.start     = 1'b1;
    dif.isize     = sz;
    dif.signed_op = sg;
    dif.dividend  = dvd;
    dif.divisor   = dvs;
    tick();
    dif.start     = 1'b0;
    dif.isize     = 1'($urandom_range(0, 1));
    dif.signed_op = 1'($urandom_range(0, 1));
    dif.dividend  = $urandom;
    dif.divisor   = 16'($urandom_range(0, 65535));
    chk({tag, "_busy"}, dif.busy, 1'b1);
    wait_done(tag, lat, seen);
    if (seen) begin
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_q"}, dif.quotient, eq);
      chk({tag, "_r"}, dif.remainder, er);
      chk({tag, "_err"}, dif.div_err, ee);
      chk({tag, "_busy_at_done"}, dif.busy, 1'b0);
      tick();
      chk({tag, "_done_low"}, dif.done, 1'b0);
      chk({tag, "_err_low"}, dif.div_err, 1'b0);
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  d0;
    n_cmp         = 0;
    n_bad         = 0;
    done_cnt      = 0;
    reset_n       = 1'b0;
    dif.start     = 1'b0;
    dif.isize     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'h0;
    dif.divisor   = 16'h0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", dif.busy, 1'b0);
    chk("rst_done", dif.done, 1'b0);
    chk("rst_err", dif.div_err, 1'b0);
    chk("rst_q", dif.quotient, 16'h0);
    chk("rst_r", dif.remainder, 16'h0);
    chk("rst_state", dif.state_dbg, 2'd0);
    reset_n = 1'b1;
    tick();

    // Plain results
    run_op("div_b",     1'b0, 1'b0, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 10);
    run_op("div_w",     1'b1, 1'b0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 18);
    run_op("idiv_b_nd", 1'b0, 1'b1, 32'h0000_FF9C, 16'h0007, 16'h00F2, 16'h00FE, 1'b0, 10);
    run_op("idiv_b_nv", 1'b0, 1'b1, 32'h0000_0064, 16'h00F9, 16'h00F2, 16'h0002, 1'b0, 10);
    // Errors keep the previous results
    run_op("div0",      1'b0, 1'b0, 32'h0000_1234, 16'h0000, 16'h00F2, 16'h0002, 1'b1, 2);
    run_op("div_b_ovf", 1'b0, 1'b0, 32'h0000_0200, 16'h0002, 16'h00F2, 16'h0002, 1'b1, 2);
    run_op("idiv_m128", 1'b0, 1'b1, 32'h0000_FF80, 16'h0001, 16'h00F2, 16'h0002, 1'b1, 10);
    run_op("idiv_w",    1'b1, 1'b1, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18);
    run_op("idiv_b127", 1'b0, 1'b1, 32'h0000_007F, 16'h0001, 16'h007F, 16'h0000, 1'b0, 10);
    run_op("idiv_w8000",1'b1, 1'b1, 32'h0000_8000, 16'h0001, 16'h007F, 16'h0000, 1'b1, 18);
    run_op("div_w_ovf", 1'b1, 1'b0, 32'hFFFF_FFFF, 16'hFFFF, 16'h007F, 16'h0000, 1'b1, 2);
    run_op("div_w_max", 1'b1, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 18);
    run_op("idiv_b_big",1'b0, 1'b1, 32'h0000_7F00, 16'h0002, 16'hFFFF, 16'hFFFE, 1'b1, 10);

    // start held high: one done per operation, restart two edges after done
    d0            = done_cnt;
    dif.start     = 1'b1;
    dif.isize     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'h0000_0064;
    dif.divisor   = 16'h0007;
    tick();
    wait_done("hold1", lat, seen);
    chk("hold1_lat", lat, 10);
    tick();
    chk("hold_gap_busy", dif.busy, 1'b0);
    chk("hold_gap_done", dif.done, 1'b0);
    tick();
    chk("hold_restart_busy", dif.busy, 1'b1);
    dif.start = 1'b0;
    wait_done("hold2", lat, seen);
    chk("hold2_lat", lat, 10);
    chk("hold2_q", dif.quotient, 16'h000E);
    repeat (3) tick();
    chk("hold_done_cnt", done_cnt - d0, 2);

    // start pulsed while busy is ignored
    d0            = done_cnt;
    dif.start     = 1'b1;
    dif.isize     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'h0000_00C8;
    dif.divisor   = 16'h000A;
    tick();
    dif.start = 1'b0;
    repeat (3) tick();
    dif.start    = 1'b1;
    dif.dividend = 32'h0000_0064;
    dif.divisor  = 16'h0007;
    tick();
    dif.start = 1'b0;
    wait_done("ign", lat, seen);
    chk("ign_lat", lat, 6);
    chk("ign_q", dif.quotient, 16'h0014);
    chk("ign_r", dif.remainder, 16'h0000);
    repeat (12) tick();
    chk("ign_done_cnt", done_cnt - d0, 1);
    chk("ign_idle", dif.busy, 1'b0);

    // Asynchronous reset during LOOP cycle 5 of a word divide
    dif.start     = 1'b1;
    dif.isize     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'h0001_0000;
    dif.divisor   = 16'h0003;
    tick();
    dif.start = 1'b0;
    repeat (5) tick();
    chk("rst_mid_busy_before", dif.busy, 1'b1);
    d0      = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", dif.busy, 1'b0);
    chk("rst_mid_done", dif.done, 1'b0);
    chk("rst_mid_err", dif.div_err, 1'b0);
    chk("rst_mid_q", dif.quotient, 16'h0);
    chk("rst_mid_r", dif.remainder, 16'h0);
    chk("rst_mid_state", dif.state_dbg, 2'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_op("after_rst", 1'b1, 1'b0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
